// File: rtl/exec_pkg.sv
// ====================================================================
// exec_pkg: op codes and MUL sequencer states for exec_unit_hs  (rev 1.0)
// ====================================================================
`default_nettype none

package exec_pkg;

  localparam logic [31:0] OP_NOP  = 32'd0;
  localparam logic [31:0] OP_ADD  = 32'd1;
  localparam logic [31:0] OP_SUB  = 32'd2;
  localparam logic [31:0] OP_AND  = 32'd3;
  localparam logic [31:0] OP_OR   = 32'd4;
  localparam logic [31:0] OP_XOR  = 32'd5;
  localparam logic [31:0] OP_SLL  = 32'd6;
  localparam logic [31:0] OP_SRL  = 32'd7;
  localparam logic [31:0] OP_SRA  = 32'd8;
  localparam logic [31:0] OP_ADDI = 32'd9;
  localparam logic [31:0] OP_ANDI = 32'd10;
  localparam logic [31:0] OP_ORI  = 32'd11;
  localparam logic [31:0] OP_XORI = 32'd12;
  localparam logic [31:0] OP_LW   = 32'd13;
  localparam logic [31:0] OP_SW   = 32'd14;
  localparam logic [31:0] OP_MUL  = 32'd15;
  localparam logic [31:0] OP_SLT  = 32'd16;
  localparam logic [31:0] OP_SLTU = 32'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/exec_unit_hs_mul_iter.sv
// ====================================================================
// mul_iter: radix-2 shift-add multiplier, low XLEN bits, one step/clk (rev 1.0)
// ====================================================================
`default_nettype none

module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] product,
  output logic [XLEN-1:0] product_next
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  acc;
  logic [CNT_W-1:0] cnt;

  // product_next is the accumulator after the step taken this cycle, so the
  // parent can forward the final value without an extra cycle.
  assign product_next = acc + (mplier[0] ? mcand : '0);
  assign product      = acc;
  assign last         = (cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_unit_hs.sv
// ====================================================================
// exec_unit_hs: valid/ready execute stage with iterative MUL and flush (rev 1.0)
// ====================================================================
`default_nettype none

module exec_unit_hs
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [4:0]        in_wb_tgt,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [15:0]       in_offset,
  input  logic              in_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [4:0]        out_wb_tgt,
  output logic [XLEN-1:0]   out_result,
  output logic [ADDR_W-1:0] out_sw_addr,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              out_done,
  output logic              busy
);

  localparam int SH_W = $clog2(XLEN);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [4:0]        tgt;
    logic [XLEN-1:0]   result;
    logic [ADDR_W-1:0] sw_addr;
    logic              ovf;
    logic              zero;
    logic              done;
  } payload_t;

  mul_state_e state, state_next;
  payload_t   slot, alu_pl, mul_pl;

  logic              slot_free, accept, is_mul, mul_wr;
  logic [OP_W-1:0]   mul_op;
  logic [4:0]        mul_tgt;
  logic              mul_done;
  logic              mul_last;
  logic [XLEN-1:0]   mul_prod, mul_prod_next, mul_res;
  logic [XLEN-1:0]   sum, diff, res;
  logic [ADDR_W-1:0] sw_addr;
  logic [SH_W-1:0]   shamt;
  logic              ovf, known;

  assign busy      = (state != ST_IDLE);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !busy && !flush && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (32'(in_op) == OP_MUL);

  assign sum   = in_a + in_b;
  assign diff  = in_a - in_b;
  assign shamt = in_b[SH_W-1:0];

  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    known   = 1'b1;
    sw_addr = '0;
    case (32'(in_op))
      OP_ADD, OP_ADDI: begin
        res = sum;
        ovf = (in_a[XLEN-1] == in_b[XLEN-1]) && (sum[XLEN-1] != in_a[XLEN-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (in_a[XLEN-1] != in_b[XLEN-1]) && (diff[XLEN-1] != in_a[XLEN-1]);
      end
      OP_AND, OP_ANDI: res = in_a & in_b;
      OP_OR,  OP_ORI:  res = in_a | in_b;
      OP_XOR, OP_XORI: res = in_a ^ in_b;
      OP_SLL:  res = in_a << shamt;
      OP_SRL:  res = in_a >> shamt;
      OP_SRA:  res = $unsigned($signed(in_a) >>> shamt);
      OP_LW:   res = sum;
      OP_SW: begin
        res     = in_a;
        sw_addr = ADDR_W'(in_b + XLEN'($signed(in_offset)));
      end
      OP_MUL:  res = '0;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: known = 1'b0;
    endcase
  end

  // Bubbles (NOP/unknown) report result 0 but keep zero low like every other flag.
  assign alu_pl = '{op: in_op, tgt: in_wb_tgt, result: res, sw_addr: sw_addr,
                    ovf: ovf, zero: known && (res == '0), done: in_done};

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (accept && is_mul),
    .step         (state == ST_MUL),
    .a            (in_a),
    .b            (in_b),
    .last         (mul_last),
    .product      (mul_prod),
    .product_next (mul_prod_next)
  );

  assign mul_res = (state == ST_HOLD) ? mul_prod : mul_prod_next;
  assign mul_pl  = '{op: mul_op, tgt: mul_tgt, result: mul_res, sw_addr: '0,
                     ovf: 1'b0, zero: (mul_res == '0), done: mul_done};

  always_comb begin
    state_next = state;
    mul_wr     = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
        ST_MUL: begin
          if (mul_last) begin
            if (slot_free) begin
              mul_wr     = 1'b1;
              state_next = ST_IDLE;
            end else begin
              state_next = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            mul_wr     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      slot      <= '0;
      mul_op    <= '0;
      mul_tgt   <= '0;
      mul_done  <= 1'b0;
    end else begin
      if (accept && is_mul) begin
        mul_op   <= in_op;
        mul_tgt  <= in_wb_tgt;
        mul_done <= in_done;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (mul_wr) begin
        slot      <= mul_pl;
        out_valid <= 1'b1;
      end else if (accept && !is_mul) begin
        slot      <= alu_pl;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_op      = slot.op;
  assign out_wb_tgt  = slot.tgt;
  assign out_result  = slot.result;
  assign out_sw_addr = slot.sw_addr;
  assign out_ovf     = slot.ovf;
  assign out_zero    = slot.zero;
  assign out_done    = slot.done;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit_hs.sv
// ====================================================================
// tb_exec_unit_hs: scoreboard bench with directed and random traffic (rev 1.0)
// ====================================================================
`default_nettype none

module tb_exec_unit_hs;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_done;
  logic [4:0]  in_op, in_wb_tgt;
  logic [31:0] in_a, in_b;
  logic [15:0] in_offset;
  wire         out_ready;
  logic        in_ready, out_valid, out_ovf, out_zero, out_done, busy;
  logic [4:0]  out_op, out_wb_tgt;
  logic [31:0] out_result;
  logic [15:0] out_sw_addr;

  always #5 clk = ~clk;

  bit   ready_rand  = 1'b0;
  logic ready_force = 1'b1;
  logic ready_bit   = 1'b1;
  assign out_ready = ready_rand ? ready_bit : ready_force;

  initial forever begin
    @(posedge clk); #1;
    ready_bit = ($urandom_range(3) != 0);
  end

  exec_unit_hs #(.XLEN(32), .ADDR_W(16), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_wb_tgt(in_wb_tgt), .in_a(in_a), .in_b(in_b),
    .in_offset(in_offset), .in_done(in_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_wb_tgt(out_wb_tgt), .out_result(out_result),
    .out_sw_addr(out_sw_addr), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_done(out_done), .busy(busy)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  tgt;
    logic [31:0] result;
    logic [15:0] sw_addr;
    logic        ovf;
    logic        zero;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural meaning of each op, in plain 64-bit arithmetic.
  function automatic exp_t model(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                 logic [15:0] off, logic [4:0] tgt, logic done);
    exp_t               e;
    longint             sa, sb, s;
    longint unsigned    p;
    logic signed [31:0] sx;
    logic [31:0]        addr;
    bit                 known;
    e = '0; e.op = op; e.tgt = tgt; e.done = done;
    sa = $signed(a); sb = $signed(b); known = 1'b1;
    case (op)
      5'd1, 5'd9: begin s = sa + sb; e.result = s[31:0];
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd2:       begin s = sa - sb; e.result = s[31:0];
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd3, 5'd10: e.result = a & b;
      5'd4, 5'd11: e.result = a | b;
      5'd5, 5'd12: e.result = a ^ b;
      5'd6:  e.result = a << b[4:0];
      5'd7:  e.result = a >> b[4:0];
      5'd8:  begin sx = a; sx = sx >>> b[4:0]; e.result = sx; end
      5'd13: e.result = a + b;
      5'd14: begin e.result = a; addr = b + {{16{off[15]}}, off}; e.sw_addr = addr[15:0]; end
      5'd15: begin p = 64'(a) * 64'(b); e.result = p[31:0]; end
      5'd16: e.result = (sa < sb) ? 32'd1 : 32'd0;
      5'd17: e.result = (a < b) ? 32'd1 : 32'd0;
      default: known = 1'b0;
    endcase
    e.zero = known && (e.result == 32'd0);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid && ready here.
  exp_t act_m, exp_m;
  always @(negedge clk) begin
    if (reset || flush) begin
      sb_q.delete();
    end else if (out_valid && out_ready) begin
      act_m = '{op: out_op, tgt: out_wb_tgt, result: out_result, sw_addr: out_sw_addr,
                ovf: out_ovf, zero: out_zero, done: out_done};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got op=%0d res=0x%h with nothing pending", out_op, out_result);
      end else begin
        exp_m = sb_q.pop_front();
        if (act_m !== exp_m) begin
          errors++;
          $display("FAIL sb_payload: got op=%0d tgt=%0d res=0x%h addr=0x%h ovf=%b z=%b d=%b expected op=%0d tgt=%0d res=0x%h addr=0x%h ovf=%b z=%b d=%b",
                   act_m.op, act_m.tgt, act_m.result, act_m.sw_addr, act_m.ovf, act_m.zero, act_m.done,
                   exp_m.op, exp_m.tgt, exp_m.result, exp_m.sw_addr, exp_m.ovf, exp_m.zero, exp_m.done);
        end
      end
    end
  end

  task automatic drive(int op, logic [31:0] a, logic [31:0] b, logic [15:0] off,
                       logic [4:0] tgt, logic done);
    in_valid = 1'b1; in_op = op[4:0]; in_a = a; in_b = b;
    in_offset = off; in_wb_tgt = tgt; in_done = done;
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(model(in_op, in_a, in_b, in_offset, in_wb_tgt, in_done));
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(int op, logic [31:0] a, logic [31:0] b, logic [15:0] off,
                       logic [4:0] tgt, logic done);
    drive(op, a, b, off, tgt, done);
    wait_accept();
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && sb_q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", sb_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_cnt, viol, vcnt, r;
    bit got;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_wb_tgt = '0;
    in_a = '0; in_b = '0; in_offset = '0; in_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_flags", {27'd0, out_valid, busy, out_ovf, out_zero, out_done}, 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_tags", {16'd0, out_sw_addr} | {22'd0, out_op, out_wb_tgt}, 32'd0);
    reset = 1'b0;

    // Signed overflow on ADD, single-cycle latency
    issue(1, 32'h7FFF_FFFF, 32'd1, 16'd0, 5'd5, 1'b0);
    chk("add_latency_valid", out_valid, 1'b1);
    chk("add_result", out_result, 32'h8000_0000);
    chk("add_ovf", out_ovf, 1'b1);
    issue(8, 32'h8000_0000, 32'h24, 16'd0, 5'd6, 1'b0);
    chk("sra_result", out_result, 32'hF800_0000);
    issue(17, 32'd1, 32'hFFFF_FFFF, 16'd0, 5'd7, 1'b0);
    chk("sltu_result", out_result, 32'd1);
    issue(16, 32'd1, 32'hFFFF_FFFF, 16'd0, 5'd8, 1'b0);
    chk("slt_result", out_result, 32'd0);
    drain();

    // MUL with an ADD waiting behind it
    issue(15, 32'd7, 32'hFFFF_FFFD, 16'd0, 5'd9, 1'b1);
    drive(1, 32'd10, 32'd20, 16'd0, 5'd3, 1'b0);
    busy_cnt = 0; viol = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && in_ready) viol++;
      if (in_ready) begin
        chk("mul_result", out_result, 32'hFFFF_FFEB);
        chk("mul_tgt", out_wb_tgt, 32'd9);
        sb_q.push_back(model(in_op, in_a, in_b, in_offset, in_wb_tgt, in_done));
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", busy_cnt, 32'd32);
    chk("mul_ready_low", viol, 32'd0);
    chk("mul_add_accepted", got, 1'b1);
    drain();

    // Output back-pressure: slot holds while stalled
    ready_force = 1'b0;
    issue(1, 32'd1, 32'd2, 16'd0, 5'd1, 1'b0);
    drive(1, 32'd3, 32'd4, 16'd0, 5'd2, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", out_result, 32'd3);
      @(posedge clk); #1;
    end
    ready_force = 1'b1;
    wait_accept();
    drain();

    // Flush on cycle 10 of a MUL
    issue(15, 32'd123, 32'd456, 16'd0, 5'd4, 1'b0);
    repeat (9) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b1);
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) vcnt++; end
    chk("flush_no_mul_result", vcnt, 32'd0);
    issue(12, 32'hF0, 32'hFF, 16'd0, 5'd10, 1'b0);
    chk("xori_result", out_result, 32'h0F);
    drain();

    // Reset in the middle of a MUL
    issue(15, 32'd5, 32'd6, 16'd0, 5'd11, 1'b1);
    repeat (5) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_flags", {27'd0, out_valid, busy, out_ovf, out_zero, out_done}, 32'd0);
    chk("midreset_result", out_result, 32'd0);
    reset = 1'b0;
    repeat (40) @(posedge clk); #1;

    // Store address and bubble with done marker
    issue(14, 32'hDEAD, 32'h0100, 16'hFFFC, 5'd12, 1'b0);
    chk("sw_addr", out_sw_addr, 32'h00FC);
    chk("sw_result", out_result, 32'hDEAD);
    issue(31, 32'd5, 32'd5, 16'd0, 5'd13, 1'b1);
    chk("bubble_result", out_result, 32'd0);
    chk("bubble_done", out_done, 1'b1);
    drain();

    // Random traffic with random downstream stalls
    ready_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r > 17) r = 31;
      issue(r, $urandom, ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(63)),
            16'($urandom), 5'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    ready_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
